// File: rtl/cache_mem_ctrl.sv
// Memory-side responder for the cache FSM: captures one request, services it against a
// word-indexed backing RAM after LATENCY cycles, and answers with a one-cycle ready pulse.

package cache_mem_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    logic                  rw;
    logic                  valid;
  } mem_req_type;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] data;
    logic                  ready;
  } mem_data_type;
endpackage

// Handshake: mem_req_i.valid is a one-cycle strobe, sampled only in IDLE or DONE;
// mem_data_o.ready is a one-cycle completion strobe, data stays stable until the next one.
module cache_mem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH_LG = 11,
  parameter int LATENCY  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  cache_mem_pkg::mem_req_type  mem_req_i,
  output cache_mem_pkg::mem_data_type mem_data_o,
  output logic                       busy_o,
  output logic                       proto_err_o,
  output logic [1:0]                 dbg_state_o
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("cache_mem_ctrl: LATENCY must be within 1..255");
  end
  if (DATA_W != cache_mem_pkg::MEM_DATA_W || ADDR_W != cache_mem_pkg::MEM_ADDR_W) begin : g_bad_width
    $error("cache_mem_ctrl: DATA_W/ADDR_W must match cache_mem_pkg widths");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DEPTH_LG-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rw_q, rw_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                ram_we;

  logic [DATA_W-1:0]   ram [0:(1<<DEPTH_LG)-1];

  // Address bits outside the word index are deliberately ignored (aliasing wraps).
  logic unused_addr;
  assign unused_addr = ^{mem_req_i.addr[ADDR_W-1:DEPTH_LG+2], mem_req_i.addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    ready_d = 1'b0;
    data_d  = data_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    case (state_q)
      BUSY: begin
        if (mem_req_i.valid) err_d = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          ready_d = 1'b1;
          ram_we  = rw_q;
          data_d  = rw_q ? wdata_q : ram[idx_q];
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        if (mem_req_i.valid) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          idx_d   = mem_req_i.addr[DEPTH_LG+1:2];
          wdata_d = mem_req_i.data;
          rw_d    = mem_req_i.rw;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // RAM is never reset; write enable derives from reset-cleared state, so an aborted write never lands.
  always_ff @(posedge clk_i) begin
    if (ram_we) ram[idx_q] <= wdata_q;
  end

  assign mem_data_o.data  = data_q;
  assign mem_data_o.ready = ready_q;
  assign busy_o           = (state_q == BUSY);
  assign proto_err_o      = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: driver pushes expected data and completion cycle,
// a negedge monitor pops and compares on every ready pulse.
module tb_cache_mem_ctrl;
  import cache_mem_pkg::*;

  localparam int LAT = 4;
  localparam int DLG = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  mem_req_type  req;
  mem_data_type rsp;
  logic         busy, perr;
  logic [1:0]   st;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rdy_seen = 0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] model [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_LG(DLG), .LATENCY(LAT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mem_req_i   (req),
    .mem_data_o  (rsp),
    .busy_o      (busy),
    .proto_err_o (perr),
    .dbg_state_o (st)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << DLG));
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rsp.ready) begin
      logic [31:0] ed;
      int          ec;
      rdy_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: ready=1 data=%h at cycle %0d, required no pulse", rsp.data, cyc);
      end else begin
        ed = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("ready_data", rsp.data, ed);
        check("ready_cycle", cyc, ec);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the capture edge with fields scrambled.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic rw);
    int i;
    i = idx_of(a);
    req.addr  = a;
    req.data  = d;
    req.rw    = rw;
    req.valid = 1'b1;
    if (rw) begin
      model[i] = d;
      exp_q.push_back(d);
    end else begin
      exp_q.push_back(model[i]);
    end
    exp_cyc_q.push_back(cyc + LAT + 1);
    @(posedge clk); #1;
    req.valid = 1'b0;
    req.addr  = $urandom;
    req.data  = $urandom;
    req.rw    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL timeout_idle: %0d responses pending after 200 cycles, required 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!rsp.ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL timeout_ready: ready=0 after 200 cycles, required 1");
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int seen0;
    req = '0;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;

    // Reset state held while idle
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("rst_ready", rsp.ready, 0);
      check("rst_busy", busy, 0);
      check("rst_data", rsp.data, 0);
      check("rst_perr", perr, 0);
    end

    // Write then read, with exact busy window
    send(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    for (int k = 1; k <= LAT; k++) begin
      check("busy_window", busy, 1);
      step(1);
    end
    check("done_busy", busy, 0);
    check("done_ready", rsp.ready, 1);
    wait_idle();
    send(32'h0000_0010, 32'h0, 1'b0);
    wait_idle();

    // Back-to-back: read captured in the write's ready cycle
    send(32'h0000_0030, 32'h0BAD_C0DE, 1'b1);
    wait_idle();
    send(32'h0000_0020, 32'h1234_5678, 1'b1);
    wait_ready();
    send(32'h0000_0030, 32'h0, 1'b0);
    wait_idle();
    send(32'h0000_0020, 32'h0, 1'b0);
    wait_idle();

    // Aliasing above the index bits
    send(32'h0000_2004, 32'hA5A5_A5A5, 1'b1);
    wait_idle();
    send(32'h0000_0004, 32'h0, 1'b0);
    wait_idle();

    // Valid while busy is dropped and flags a sticky protocol error
    check("perr_before", perr, 0);
    send(32'h0000_0050, 32'h1111_1111, 1'b1);
    step(1);
    req.addr = 32'h0000_0050; req.data = 32'h9999_9999; req.rw = 1'b1; req.valid = 1'b1;
    step(1);
    req.valid = 1'b0;
    wait_idle();
    check("perr_set", perr, 1);
    send(32'h0000_0050, 32'h0, 1'b0);
    wait_idle();

    // Randomized traffic with mixed gaps and back-to-back issue
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic        rw;
      a  = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(16, 31)) << 2) | 32'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      if (!model.exists(idx_of(a))) rw = 1'b1;
      send(a, $urandom, rw);
      if ($urandom_range(0, 2) == 0) wait_ready();
      else begin
        wait_idle();
        step($urandom_range(0, 3));
      end
    end
    wait_idle();
    check("perr_sticky", perr, 1);

    // Reset in the middle of a write: no ready, RAM keeps prior content
    send(32'h0000_0040, 32'h7777_7777, 1'b1);
    wait_idle();
    req.addr = 32'h0000_0040; req.data = 32'hCAFE_F00D; req.rw = 1'b1; req.valid = 1'b1;
    step(1);
    req.valid = 1'b0;
    step(1);
    seen0 = rdy_seen;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_data", rsp.data, 0);
    check("abort_perr", perr, 0);
    step(8);
    check("abort_no_ready", rdy_seen, seen0);
    send(32'h0000_0040, 32'h0, 1'b0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
